// File: rtl/sfp_status_monitor.sv
// SFP ABS/LOS conditioning: per-channel synchroniser, debounce, edge-qualified
// sticky interrupt flags with write-1-to-clear, and masked interrupt reduction.

module sfp_status_monitor_src #(
    parameter int N_CH        = 8,
    parameter int DEB_CNT     = 3,
    parameter int SYNC_STAGES = 2,
    parameter int STAT_RST    = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sample_tick,
    input  logic [N_CH-1:0] pin,
    input  logic [1:0]      edge_sel,
    input  logic [N_CH-1:0] clr,
    output logic [N_CH-1:0] stat,
    output logic [N_CH-1:0] flags
);

    localparam int              CW        = $clog2(DEB_CNT + 1);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(DEB_CNT - 1);
    localparam logic            STAT_BIT  = (STAT_RST != 0);
    localparam logic [N_CH-1:0] STAT_INIT = {N_CH{STAT_BIT}};

    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] sync_d [SYNC_STAGES];
    logic [CW-1:0]   cnt_q  [N_CH];
    logic [CW-1:0]   cnt_d  [N_CH];
    logic [N_CH-1:0] stat_q;
    logic [N_CH-1:0] stat_d;
    logic [N_CH-1:0] prev_q;
    logic [N_CH-1:0] prev_d;
    logic [N_CH-1:0] flag_q;
    logic [N_CH-1:0] flag_d;
    logic [N_CH-1:0] level_s;
    logic [N_CH-1:0] rise_s;
    logic [N_CH-1:0] fall_s;
    logic [N_CH-1:0] evt_s;

    // Synchroniser chain runs every clock, independent of the sample tick.
    always_comb begin
        sync_d[0] = pin;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= STAT_INIT;
            end
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
        end
    end

    assign level_s = sync_q[SYNC_STAGES-1];

    // Debounce: a differing level must be seen on DEB_CNT consecutive ticks;
    // any matching sample restarts the count.
    always_comb begin
        stat_d = stat_q;
        for (int ch = 0; ch < N_CH; ch++) begin
            cnt_d[ch] = cnt_q[ch];
            if (!sample_tick) begin
                cnt_d[ch] = cnt_q[ch];
            end else if (level_s[ch] == stat_q[ch]) begin
                cnt_d[ch] = {CW{1'b0}};
            end else if (cnt_q[ch] == CNT_LAST) begin
                stat_d[ch] = level_s[ch];
                cnt_d[ch]  = {CW{1'b0}};
            end else begin
                cnt_d[ch] = cnt_q[ch] + CW'(1);
            end
        end
    end

    always_comb begin
        prev_d = stat_q;
        rise_s = stat_q & ~prev_q;
        fall_s = ~stat_q & prev_q;
        case (edge_sel)
            2'b00:   evt_s = {N_CH{1'b0}};
            2'b01:   evt_s = rise_s;
            2'b10:   evt_s = fall_s;
            2'b11:   evt_s = rise_s | fall_s;
            default: evt_s = {N_CH{1'b0}};
        endcase
        // A new event overrides a clear hitting the same bit.
        flag_d = (flag_q & ~clr) | evt_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q <= STAT_INIT;
            prev_q <= STAT_INIT;
            flag_q <= {N_CH{1'b0}};
            for (int ch = 0; ch < N_CH; ch++) begin
                cnt_q[ch] <= {CW{1'b0}};
            end
        end else begin
            stat_q <= stat_d;
            prev_q <= prev_d;
            flag_q <= flag_d;
            for (int ch = 0; ch < N_CH; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
        end
    end

    assign stat  = stat_q;
    assign flags = flag_q;

endmodule

module sfp_status_monitor #(
    parameter int N_CH        = 8,
    parameter int DEB_CNT     = 3,
    parameter int SYNC_STAGES = 2,
    parameter int STAT_RST    = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sample_tick,
    input  logic [N_CH-1:0] abs_pin,
    input  logic [N_CH-1:0] los_pin,
    input  logic [1:0]      abs_edge_sel,
    input  logic [1:0]      los_edge_sel,
    input  logic [N_CH-1:0] abs_mask,
    input  logic [N_CH-1:0] los_mask,
    input  logic            clr_we,
    input  logic            clr_sel,
    input  logic [N_CH-1:0] clr_data,
    output logic [N_CH-1:0] abs_stat,
    output logic [N_CH-1:0] los_stat,
    output logic [N_CH-1:0] abs_int,
    output logic [N_CH-1:0] los_int,
    output logic            abs_int_bit,
    output logic            los_int_bit,
    output logic            irq
);

    logic [N_CH-1:0] abs_clr_s;
    logic [N_CH-1:0] los_clr_s;
    logic            irq_q;
    logic            irq_d;

    // Route the write-1-to-clear pattern to the selected source only.
    always_comb begin
        abs_clr_s = {N_CH{1'b0}};
        los_clr_s = {N_CH{1'b0}};
        if (clr_we && !clr_sel) begin
            abs_clr_s = clr_data;
        end else if (clr_we && clr_sel) begin
            los_clr_s = clr_data;
        end else begin
            abs_clr_s = {N_CH{1'b0}};
            los_clr_s = {N_CH{1'b0}};
        end
    end

    sfp_status_monitor_src #(
        .N_CH        (N_CH),
        .DEB_CNT     (DEB_CNT),
        .SYNC_STAGES (SYNC_STAGES),
        .STAT_RST    (STAT_RST)
    ) u_abs (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .pin         (abs_pin),
        .edge_sel    (abs_edge_sel),
        .clr         (abs_clr_s),
        .stat        (abs_stat),
        .flags       (abs_int)
    );

    sfp_status_monitor_src #(
        .N_CH        (N_CH),
        .DEB_CNT     (DEB_CNT),
        .SYNC_STAGES (SYNC_STAGES),
        .STAT_RST    (STAT_RST)
    ) u_los (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .pin         (los_pin),
        .edge_sel    (los_edge_sel),
        .clr         (los_clr_s),
        .stat        (los_stat),
        .flags       (los_int)
    );

    // Masks gate only the summary bits, so unmasking a pending flag shows at once.
    assign abs_int_bit = |(abs_int & ~abs_mask);
    assign los_int_bit = |(los_int & ~los_mask);

    always_comb begin
        irq_d = abs_int_bit | los_int_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_sfp_status_monitor.sv
// Directed bench for sfp_status_monitor: two instances (8ch/DEB 3, 16ch/DEB 1)
// checked through a cycle-stamped expectation queue drained by a monitor.

module tb_sfp_status_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        sample_tick;
    // Instance A: N_CH=8, DEB_CNT=3
    logic        rst_a;
    logic [7:0]  abs_pin_a, los_pin_a, abs_mask_a, los_mask_a, clr_data_a;
    logic [1:0]  abs_edge_sel_a, los_edge_sel_a;
    logic        clr_we_a, clr_sel_a;
    logic [7:0]  abs_stat_a, los_stat_a, abs_int_a, los_int_a;
    logic        abs_int_bit_a, los_int_bit_a, irq_a;
    // Instance B: N_CH=16, DEB_CNT=1
    logic        rst_b;
    logic [15:0] abs_pin_b, los_pin_b, abs_mask_b, los_mask_b, clr_data_b;
    logic [1:0]  abs_edge_sel_b, los_edge_sel_b;
    logic        clr_we_b, clr_sel_b;
    logic [15:0] abs_stat_b, los_stat_b, abs_int_b, los_int_b;
    logic        abs_int_bit_b, los_int_bit_b, irq_b;

    sfp_status_monitor #(.N_CH(8), .DEB_CNT(3), .SYNC_STAGES(2), .STAT_RST(1)) dut_a (
        .clk(clk), .rst(rst_a), .sample_tick(sample_tick),
        .abs_pin(abs_pin_a), .los_pin(los_pin_a),
        .abs_edge_sel(abs_edge_sel_a), .los_edge_sel(los_edge_sel_a),
        .abs_mask(abs_mask_a), .los_mask(los_mask_a),
        .clr_we(clr_we_a), .clr_sel(clr_sel_a), .clr_data(clr_data_a),
        .abs_stat(abs_stat_a), .los_stat(los_stat_a),
        .abs_int(abs_int_a), .los_int(los_int_a),
        .abs_int_bit(abs_int_bit_a), .los_int_bit(los_int_bit_a), .irq(irq_a)
    );

    sfp_status_monitor #(.N_CH(16), .DEB_CNT(1), .SYNC_STAGES(2), .STAT_RST(1)) dut_b (
        .clk(clk), .rst(rst_b), .sample_tick(sample_tick),
        .abs_pin(abs_pin_b), .los_pin(los_pin_b),
        .abs_edge_sel(abs_edge_sel_b), .los_edge_sel(los_edge_sel_b),
        .abs_mask(abs_mask_b), .los_mask(los_mask_b),
        .clr_we(clr_we_b), .clr_sel(clr_sel_b), .clr_data(clr_data_b),
        .abs_stat(abs_stat_b), .los_stat(los_stat_b),
        .abs_int(abs_int_b), .los_int(los_int_b),
        .abs_int_bit(abs_int_bit_b), .los_int_bit(los_int_bit_b), .irq(irq_b)
    );

    // Observed tuple: {abs_stat, los_stat, abs_int, los_int, abs_int_bit, los_int_bit, irq}
    logic [66:0] act_a, act_b;
    assign act_a = {8'h00, abs_stat_a, 8'h00, los_stat_a, 8'h00, abs_int_a, 8'h00, los_int_a,
                    abs_int_bit_a, los_int_bit_a, irq_a};
    assign act_b = {abs_stat_b, los_stat_b, abs_int_b, los_int_b,
                    abs_int_bit_b, los_int_bit_b, irq_b};

    typedef struct {
        int          cyc;
        bit          dut;
        string       name;
        logic [66:0] v;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   done  = 1'b0;

    // Monitor: compare the queue head in the cycle it is stamped for.
    initial begin
        exp_t        e;
        logic [66:0] got;
        forever begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                total++;
                bad++;
                $display("FAIL %s: got no sample, required sample in cycle %0d", e.name, e.cyc);
            end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e   = sb.pop_front();
                got = e.dut ? act_b : act_a;
                total++;
                if (got !== e.v) begin
                    bad++;
                    $display("FAIL %s: got %h required %h", e.name, got, e.v);
                end
            end else if (done && sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                bad++;
                $display("FAIL %s: never checked", e.name);
            end
        end
    end

    task automatic chk(input bit dut, input string nm,
                       input logic [15:0] as, input logic [15:0] ls,
                       input logic [15:0] ai, input logic [15:0] li,
                       input logic ab, input logic lb, input logic iq);
        exp_t e;
        e.cyc  = cyc;
        e.dut  = dut;
        e.name = nm;
        e.v    = {as, ls, ai, li, ab, lb, iq};
        sb.push_back(e);
    endtask

    task automatic clk_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        clk_n(1);
        sample_tick = 1'b0;
    endtask

    // Sync through, then three debounce ticks (instance A).
    task automatic deb_a();
        clk_n(3);
        tick();
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        sample_tick = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1;
        abs_pin_a = 8'hFF; los_pin_a = 8'hFF; abs_mask_a = 8'h00; los_mask_a = 8'h00;
        abs_edge_sel_a = 2'b10; los_edge_sel_a = 2'b11;
        clr_we_a = 1'b0; clr_sel_a = 1'b0; clr_data_a = 8'h00;
        abs_pin_b = 16'hFFFF; los_pin_b = 16'hFFFF; abs_mask_b = 16'h0000; los_mask_b = 16'h0000;
        abs_edge_sel_b = 2'b11; los_edge_sel_b = 2'b11;
        clr_we_b = 1'b0; clr_sel_b = 1'b0; clr_data_b = 16'h0000;

        clk_n(3);
        chk(1'b0, "rst_a", 16'h00FF, 16'h00FF, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        clk_n(1);
        chk(1'b1, "rst_b", 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        rst_a = 1'b0; rst_b = 1'b0;
        deb_a();
        clk_n(2);
        chk(1'b0, "idle_a", 16'h00FF, 16'h00FF, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        clk_n(1);
        chk(1'b1, "idle_b", 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

        // ABS ch2 falls, falling edges selected
        abs_pin_a[2] = 1'b0;
        clk_n(3);
        tick();
        chk(1'b0, "deb_tick1", 16'h00FF, 16'h00FF, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk(1'b0, "deb_tick2", 16'h00FF, 16'h00FF, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk(1'b0, "abs_stat", 16'h00FB, 16'h00FF, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        clk_n(1);
        chk(1'b0, "abs_flag", 16'h00FB, 16'h00FF, 16'h04, 16'h0, 1'b1, 1'b0, 1'b0);
        clk_n(1);
        chk(1'b0, "irq_set", 16'h00FB, 16'h00FF, 16'h04, 16'h0, 1'b1, 1'b0, 1'b1);

        // LOS ch5 glitches for two ticks, twice, with a matching sample between
        los_pin_a[5] = 1'b0; clk_n(3); tick(); tick();
        los_pin_a[5] = 1'b1; clk_n(3); tick();
        los_pin_a[5] = 1'b0; clk_n(3); tick(); tick();
        chk(1'b0, "glitch_mid", 16'h00FB, 16'h00FF, 16'h04, 16'h0, 1'b1, 1'b0, 1'b1);
        los_pin_a[5] = 1'b1; clk_n(3); tick(); clk_n(1);
        chk(1'b0, "glitch_end", 16'h00FB, 16'h00FF, 16'h04, 16'h0, 1'b1, 1'b0, 1'b1);

        // Clears aimed at the other source or at zero bits leave the flag
        clr_we_a = 1'b1; clr_sel_a = 1'b1; clr_data_a = 8'hFF;
        clk_n(1);
        clr_we_a = 1'b0;
        chk(1'b0, "clr_other", 16'h00FB, 16'h00FF, 16'h04, 16'h0, 1'b1, 1'b0, 1'b1);
        clr_we_a = 1'b1; clr_sel_a = 1'b0; clr_data_a = 8'hFB;
        clk_n(1);
        clr_we_a = 1'b0;
        chk(1'b0, "clr_zero_bits", 16'h00FB, 16'h00FF, 16'h04, 16'h0, 1'b1, 1'b0, 1'b1);

        // Rising event on ch2 coincides with a clear of ch2: set wins
        abs_edge_sel_a = 2'b11;
        abs_pin_a[2] = 1'b1;
        deb_a();
        clr_we_a = 1'b1; clr_sel_a = 1'b0; clr_data_a = 8'h04;
        clk_n(1);
        clr_we_a = 1'b0;
        chk(1'b0, "set_wins", 16'h00FF, 16'h00FF, 16'h04, 16'h0, 1'b1, 1'b0, 1'b1);
        clr_we_a = 1'b1;
        clk_n(1);
        clr_we_a = 1'b0;
        chk(1'b0, "clr_abs", 16'h00FF, 16'h00FF, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        clk_n(1);
        chk(1'b0, "irq_clr", 16'h00FF, 16'h00FF, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Edge select filtering
        abs_edge_sel_a = 2'b01;
        abs_pin_a[7] = 1'b0;
        deb_a(); clk_n(2);
        chk(1'b0, "rise_only", 16'h007F, 16'h00FF, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        abs_edge_sel_a = 2'b00;
        abs_pin_a[7] = 1'b1;
        deb_a(); clk_n(2);
        chk(1'b0, "sel_none", 16'h00FF, 16'h00FF, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Masked LOS event on ch0, then unmask
        los_mask_a = 8'hFF;
        los_pin_a[0] = 1'b0;
        deb_a(); clk_n(1);
        chk(1'b0, "los_masked", 16'h00FF, 16'h00FE, 16'h0, 16'h01, 1'b0, 1'b0, 1'b0);
        clk_n(1);
        chk(1'b0, "irq_masked", 16'h00FF, 16'h00FE, 16'h0, 16'h01, 1'b0, 1'b0, 1'b0);
        clk_n(1);
        los_mask_a = 8'hFE;
        chk(1'b0, "unmask", 16'h00FF, 16'h00FE, 16'h0, 16'h01, 1'b0, 1'b1, 1'b0);
        clk_n(1);
        chk(1'b0, "irq_unmask", 16'h00FF, 16'h00FE, 16'h0, 16'h01, 1'b0, 1'b1, 1'b1);

        // Instance B: single-tick debounce, then reset mid-count
        los_pin_b[15] = 1'b0;
        clk_n(3); tick();
        chk(1'b1, "b_stat", 16'hFFFF, 16'h7FFF, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        clk_n(1);
        chk(1'b1, "b_flag", 16'hFFFF, 16'h7FFF, 16'h0, 16'h8000, 1'b0, 1'b1, 1'b0);
        clk_n(1);
        chk(1'b1, "b_irq", 16'hFFFF, 16'h7FFF, 16'h0, 16'h8000, 1'b0, 1'b1, 1'b1);
        los_pin_b[15] = 1'b1;
        clk_n(2);
        rst_b = 1'b1;
        chk(1'b1, "b_rst", 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        clk_n(2);
        rst_b = 1'b0;
        tick(); clk_n(2);
        chk(1'b1, "b_post_rst", 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

        clk_n(2);
        done = 1'b1;
        while (sb.size() > 0) clk_n(1);
        clk_n(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
